// File: rtl/sram_bist_pkg.sv
// Shared types and defaults for the SRAM BIST master: FSM state encoding,
// LFSR feedback taps and default bus/counter widths.
package sram_bist_pkg;

   localparam int DEF_AW    = 14;
   localparam int DEF_DW    = 32;
   localparam int DEF_LEN_W = 15;
   localparam int DEF_CNT_W = 16;

   // Galois feedback for x^32 + x^22 + x^2 + x + 1.
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      READ,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/sram_bist_patgen.sv
// Pattern generator: 'pattern' is the word for the current index; load/advance step it.
// Default is seed+i; defining SRAM_BIST_LFSR_EN selects a 32-bit Galois LFSR instead.
module sram_bist_patgen
   import sram_bist_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [DW-1:0] seed,
   input  logic          advance,
   output logic [DW-1:0] pattern
);

   logic [DW-1:0] cur;
   logic [DW-1:0] first;
   logic [DW-1:0] step;

`ifdef SRAM_BIST_LFSR_EN
   // An all-zero state would lock the LFSR, so a zero seed starts at 1.
   assign first = (seed == '0) ? DW'(1) : seed;
   assign step  = (pattern >> 1) ^ (pattern[0] ? LFSR_TAPS : '0);
`else
   assign first = seed;
   assign step  = pattern + 1'b1;
`endif

   // Loading bypasses the register so word 0 can go out on the same edge.
   assign pattern = load ? first : cur;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= '0;
      end else if (load || advance) begin
         cur <= step;
      end
   end

endmodule

// File: rtl/sram_bist_master.sv
// Avalon-MM BIST master for the on-chip SRAM: fill a word range, read it back, compare.
// Build option: SRAM_BIST_LFSR_EN selects the LFSR pattern (see sram_bist_patgen).
module sram_bist_master
   import sram_bist_pkg::*;
#(
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW,
   parameter int LEN_W = DEF_LEN_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [AW-1:0]     base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [DW-1:0]     seed,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_count,
   output logic [AW-1:0]     err_addr,
   output logic [DW-1:0]     err_data,
   output logic [DW-1:0]     err_exp,
   output logic [AW-1:0]     m_address,
   output logic              m_chipselect,
   output logic              m_write,
   output logic [DW-1:0]     m_writedata,
   output logic [DW/8-1:0]   m_byteenable,
   output logic              m_clken,
   input  logic [DW-1:0]     m_readdata
);

   state_t           state, state_nx;
   logic [AW-1:0]    base_q, cmp_addr, addr_nx;
   logic [LEN_W-1:0] len_q, idx, idx_nx;
   logic [DW-1:0]    seed_q, exp_q, exp_nx, cmp_exp, wdata_nx;
   logic [DW-1:0]    pg_seed, pattern;
   logic             cs_nx, wr_nx, cmp_valid;
   logic             accept, halt, last, pg_load, pg_advance, mismatch;
   logic [CNT_W-1:0] err_count_nx;

   assign accept       = (state == IDLE) && start && !abort;
   assign halt         = abort && (state inside {FILL, READ, DRAIN});
   assign last         = (idx == len_q);
   assign busy         = state inside {FILL, READ, DRAIN};
   assign m_byteenable = '1;
   assign m_clken      = 1'b1;

   assign pg_seed    = (state == IDLE) ? seed : seed_q;
   assign pg_load    = (accept && length != '0) || (state == FILL && !abort && last);
   assign pg_advance = (state inside {FILL, READ}) && !abort && !last;

   sram_bist_patgen #(.DW(DW)) u_patgen (
      .clk     (clk),
      .reset   (reset),
      .load    (pg_load),
      .seed    (pg_seed),
      .advance (pg_advance),
      .pattern (pattern)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = (length == '0) ? DONE : FILL;
         FILL:    if (abort) state_nx = IDLE; else if (last) state_nx = READ;
         READ:    if (abort) state_nx = IDLE; else if (last) state_nx = DRAIN;
         DRAIN:   state_nx = abort ? IDLE : DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      cs_nx    = 1'b0;
      wr_nx    = 1'b0;
      addr_nx  = m_address;
      wdata_nx = m_writedata;
      exp_nx   = exp_q;
      idx_nx   = idx;
      unique case (state)
         IDLE: if (accept && length != '0) begin
            cs_nx    = 1'b1;
            wr_nx    = 1'b1;
            addr_nx  = base_addr;
            wdata_nx = pattern;
            idx_nx   = LEN_W'(1);
         end
         FILL: if (!abort) begin
            cs_nx = 1'b1;
            if (!last) begin
               wr_nx    = 1'b1;
               addr_nx  = base_q + AW'(idx);
               wdata_nx = pattern;
               idx_nx   = idx + 1'b1;
            end else begin
               addr_nx = base_q;
               exp_nx  = pattern;
               idx_nx  = LEN_W'(1);
            end
         end
         READ: if (!abort && !last) begin
            cs_nx   = 1'b1;
            addr_nx = base_q + AW'(idx);
            exp_nx  = pattern;
            idx_nx  = idx + 1'b1;
         end
         default: ;
      endcase
   end

   // Read data arrives one cycle after issue; cmp_* hold that read's address and expectation.
   assign mismatch     = cmp_valid && !halt && (m_readdata != cmp_exp);
   assign err_count_nx = (mismatch && err_count != '1) ? err_count + 1'b1 : err_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         m_chipselect <= 1'b0;
         m_write      <= 1'b0;
         m_address    <= '0;
         m_writedata  <= '0;
         idx          <= '0;
         exp_q        <= '0;
         cmp_valid    <= 1'b0;
         cmp_addr     <= '0;
         cmp_exp      <= '0;
         base_q       <= '0;
         len_q        <= '0;
         seed_q       <= '0;
         done         <= 1'b0;
         pass         <= 1'b0;
         err_count    <= '0;
         err_addr     <= '0;
         err_data     <= '0;
         err_exp      <= '0;
      end else begin
         m_chipselect <= cs_nx;
         m_write      <= wr_nx;
         m_address    <= addr_nx;
         m_writedata  <= wdata_nx;
         idx          <= idx_nx;
         exp_q        <= exp_nx;
         cmp_valid    <= m_chipselect && !m_write && !halt;
         cmp_addr     <= m_address;
         cmp_exp      <= exp_q;
         if (accept) begin
            base_q <= base_addr;
            len_q  <= length;
            seed_q <= seed;
         end
         if (accept && length != '0) begin
            done      <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
            err_data  <= '0;
            err_exp   <= '0;
         end else begin
            err_count <= err_count_nx;
            if (mismatch && err_count == '0) begin
               err_addr <= cmp_addr;
               err_data <= m_readdata;
               err_exp  <= cmp_exp;
            end
         end
         if (state_nx == DONE) begin
            done <= 1'b1;
            pass <= (err_count_nx == '0);
         end
      end
   end

endmodule

// File: doc/sram_bist_master.md
# sram_bist_master

Avalon-MM master that drives the single-port on-chip SRAM's s1 port directly: fills a word range with a generated pattern, reads it back, and compares. Used for power-on memory test and bring-up diagnostics alongside the Nios II. Control is a start/abort strobe pair and a status bundle that the CSR wrapper exposes to software.

## Interface
- AW, 14, word-address width; matches the SRAM's 14-bit address.
- DW, 32, data width; byteenable width is DW/8.
- LEN_W, 15, width of the word-count field; covers the full 10240-word depth.
- CNT_W, 16, width of the saturating error counter.
- clk  in  1  clock; SRAM shares this clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle strobe; ignored unless the block is IDLE.
- abort  in  1  one-cycle strobe; stops the test.
- base_addr  in  AW  first word address.
- length  in  LEN_W  number of words to test.
- seed  in  DW  pattern seed.
- busy  out  1  high from start acceptance until DONE or abort.
- done  out  1  sticky; set on completion, cleared by the next accepted start.
- pass  out  1  valid when done=1; high when err_count=0.
- err_count  out  CNT_W  mismatch count; saturates at all-ones.
- err_addr  out  AW  address of the first mismatch.
- err_data  out  DW  read data at the first mismatch.
- err_exp  out  DW  expected data at the first mismatch.
- m_address  out  AW  to SRAM address.
- m_chipselect  out  1  to SRAM chipselect.
- m_write  out  1  to SRAM write.
- m_writedata  out  DW  to SRAM writedata.
- m_byteenable  out  DW/8  constant all-ones.
- m_clken  out  1  constant 1.
- m_readdata  in  DW  from SRAM readdata; fixed read latency of 1 cycle.

## Operation
- Reset values: busy=0, done=0, pass=0, err_*=0, err_count=0, m_chipselect=0, m_write=0, m_address=0, m_writedata=0. The state is IDLE.
- States:
  - IDLE: on start, latch base_addr, length, and seed. If length=0, go to DONE. Otherwise load the pattern generator, go to FILL, clear done, and clear the err_* fields.
  - FILL: issue one write per cycle. For word i, the address is (base_addr+i) mod 2^AW and the data is pat(i). After word length-1, reload the generator with the latched seed and go to READ.
  - READ: issue one read per cycle (chipselect=1, write=0) for the same addresses. The expected value for i is pat(i), registered one cycle to align with m_readdata. After the last read is issued, go to DRAIN.
  - DRAIN: compare the final read. m_chipselect=0. Go to DONE.
  - DONE: set done=1, set pass=(err_count==0), busy=0. Return to IDLE in the same cycle. The done flag holds.
- Pattern, default: pat(i)=seed+i, modulo 2^DW.
- Compare happens in the cycle after each read issue. On a mismatch, increment err_count with saturation. Capture err_addr, err_data, and err_exp only when err_count was 0.
- Abort in FILL, READ, or DRAIN: deassert m_chipselect and m_write in the next cycle, go to IDLE, busy=0, done stays 0. Any in-flight compare is discarded. Abort in IDLE has no effect.
- Start while busy is ignored. Start and abort in the same IDLE cycle: abort wins, start is dropped.
- Address wraparound at 2^AW is silent. Words beyond the SRAM depth are the caller's responsibility.

## Timing
- Start seen at cycle 0: busy=1 at cycle 1, first write at cycle 1.
- Writes occupy cycles 1..L. Reads occupy L+1..2L. The final compare happens at 2L+1 (DRAIN). done=1 at 2L+2.
- Total latency from start to done is 2L+2 cycles. For L=0, done=1 at cycle 1 with no bus activity.
- m_* outputs are registered. There are no waitrequest stalls; the bus is owned exclusively during the test.

## Configuration
- SRAM_BIST_LFSR_EN defined: pat(0)=seed, or 32'h1 if seed=0. pat(i+1) is a Galois LFSR step of pat(i) with taps 32'h8020_0003 (x^32+x^22+x^2+x+1). DW is fixed at 32.
- Not defined: incrementing pattern only, and no LFSR logic is synthesized.

## Structure
- Package sram_bist_pkg holds the state enum (IDLE, FILL, READ, DRAIN, DONE), the LFSR tap constant, and the default parameter values.
- One sub-module, sram_bist_patgen, with ports load, seed, advance, and pattern. It is instantiated once and reloaded between FILL and READ. The LFSR branch sits inside it under the macro.

## Test plan
- base=0x0100, length=4, seed=0xA000_0000 → writes 0xA0000000..0xA0000003 to 0x100..0x103. done at cycle 10, pass=1, err_count=0.
- Same run with the SRAM model corrupting address 0x102 to 0xDEADBEEF → err_count=1, err_addr=0x102, err_data=0xDEADBEEF, err_exp=0xA0000002, pass=0.
- length=0 → done=1 at cycle 1, m_chipselect never asserted.
- base=0x3FFE, length=4 → addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001 in both phases.
- Abort at cycle 3 of a length=8 run → bus idle at cycle 4, busy=0, done=0. A start pulsed during busy is ignored.
- With SRAM_BIST_LFSR_EN, seed=0 → first word written is 0x00000001, second is 0x80200003, and the run passes.
